// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding / load-use hazard unit with a shifting producer scoreboard
// covering the DEPTH stages after ID.
module fwd_hazard_scoreboard #(
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 3,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 16,
    localparam int SELW      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_regwrite,
    input  logic                      id_is_load,
    input  logic                      pipe_stall,
    input  logic                      flush,
    output logic                      hazard_stall,
    output logic                      ex_valid,
    output logic [NUM_SRC*SELW-1:0]   ex_fwd_sel,
    output logic [CNT_W-1:0]          stall_count
);

    logic              ent_valid [1:DEPTH];
    logic [REG_AW-1:0] ent_rd    [1:DEPTH];
    logic              ent_rw    [1:DEPTH];
    logic              ent_ld    [1:DEPTH];

    logic [DEPTH:1]           hit [NUM_SRC];
    logic                     load_hit;
    logic [NUM_SRC*SELW-1:0]  sel_next;
    logic                     bubble;
    logic                     fwd_ok;

    // hit[s][k]: stage k holds a live producer of source s (r0 excluded)
    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = 1; k <= DEPTH; k++) begin
                hit[s][k] = ent_valid[k] && ent_rw[k]
                          && (ent_rd[k] != '0)
                          && (ent_rd[k] == id_src[s*REG_AW +: REG_AW]);
            end
        end
    end

    always_comb begin
        load_hit = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = 1; k <= DEPTH; k++) begin
                if (k <= LOAD_READY - 2 && id_src_used[s]
                    && hit[s][k] && ent_ld[k]) begin
                    load_hit = 1'b1;
                end
            end
        end
        hazard_stall = id_valid && !flush && !reset && load_hit;
    end

    // Scan oldest to youngest so the youngest producer overwrites
    always_comb begin
        sel_next = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                if (id_src_used[s] && hit[s][k]) begin
                    sel_next[s*SELW +: SELW] = SELW'(k + 1);
                end
            end
        end
    end

    assign bubble = flush || hazard_stall || !id_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                ent_valid[k] <= 1'b0;
                ent_rd[k]    <= '0;
                ent_rw[k]    <= 1'b0;
                ent_ld[k]    <= 1'b0;
            end
            ex_valid    <= 1'b0;
            ex_fwd_sel  <= '0;
            stall_count <= '0;
        end else if (!pipe_stall) begin
            for (int k = 2; k <= DEPTH; k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_rd[k]    <= ent_rd[k-1];
                ent_rw[k]    <= ent_rw[k-1];
                ent_ld[k]    <= ent_ld[k-1];
            end
            if (bubble) begin
                ent_valid[1] <= 1'b0;
                ent_rd[1]    <= '0;
                ent_rw[1]    <= 1'b0;
                ent_ld[1]    <= 1'b0;
                ex_valid     <= 1'b0;
                ex_fwd_sel   <= '0;
            end else begin
                ent_valid[1] <= 1'b1;
                ent_rd[1]    <= id_rd;
                ent_rw[1]    <= id_regwrite;
                ent_ld[1]    <= id_is_load;
                ex_valid     <= 1'b1;
                ex_fwd_sel   <= sel_next;
            end
            if (hazard_stall && stall_count != '1) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

    // A select must never point at a load whose data is not yet available
    always_comb begin
        fwd_ok = 1'b1;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = 1; k <= DEPTH; k++) begin
                if (ex_fwd_sel[s*SELW +: SELW] == SELW'(k)
                    && k < LOAD_READY
                    && ent_valid[k] && ent_ld[k]) begin
                    fwd_ok = 1'b0;
                end
            end
        end
    end

    assert property (@(posedge clk) disable iff (reset) fwd_ok);

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Scenario bench for fwd_hazard_scoreboard: expected EX-stage results
// are queued as each ID instruction is driven and checked one cycle later.
module tb_fwd_hazard_scoreboard;

    localparam int NUM_SRC = 2;
    localparam int DEPTH   = 3;
    localparam int REG_AW  = 5;
    localparam int CNT_W   = 4;
    localparam int SELW    = 2;

    logic                      clk;
    logic                      reset;
    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_src;
    logic [NUM_SRC-1:0]        id_src_used;
    logic [REG_AW-1:0]         id_rd;
    logic                      id_regwrite;
    logic                      id_is_load;
    logic                      pipe_stall;
    logic                      flush;
    logic                      hazard_stall;
    logic                      ex_valid;
    logic [NUM_SRC*SELW-1:0]   ex_fwd_sel;
    logic [CNT_W-1:0]          stall_count;

    fwd_hazard_scoreboard #(
        .NUM_SRC(NUM_SRC),
        .DEPTH(DEPTH),
        .LOAD_READY(3),
        .REG_AW(REG_AW),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .id_valid(id_valid),
        .id_src(id_src),
        .id_src_used(id_src_used),
        .id_rd(id_rd),
        .id_regwrite(id_regwrite),
        .id_is_load(id_is_load),
        .pipe_stall(pipe_stall),
        .flush(flush),
        .hazard_stall(hazard_stall),
        .ex_valid(ex_valid),
        .ex_fwd_sel(ex_fwd_sel),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // exp = {ex_valid, sel1, sel0}
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic [4:0] s0;
        logic [4:0] s1;
        logic [1:0] used;
        logic       rw;
        logic       ld;
        logic       hz;
        logic [4:0] exp;
    } stim_t;

    int         tests;
    int         failed;
    logic [4:0] exp_q[$];
    logic [4:0] got;
    logic [4:0] want;
    logic [CNT_W-1:0] cnt0;

    function automatic stim_t mk(
        input logic v, input logic [4:0] rd, input logic [4:0] s0,
        input logic [4:0] s1, input logic [1:0] used, input logic rw,
        input logic ld, input logic hz, input logic [4:0] exp);
        stim_t t;
        t.v = v; t.rd = rd; t.s0 = s0; t.s1 = s1; t.used = used;
        t.rw = rw; t.ld = ld; t.hz = hz; t.exp = exp;
        return t;
    endfunction

    task automatic set_id(
        input logic v, input logic [4:0] rd, input logic [4:0] s0,
        input logic [4:0] s1, input logic [1:0] used, input logic rw,
        input logic ld);
        id_valid    = v;
        id_rd       = rd;
        id_src      = {s1, s0};
        id_src_used = used;
        id_regwrite = rw;
        id_is_load  = ld;
        pipe_stall  = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle3();
        set_id(0, 0, 0, 0, 2'b00, 0, 0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        set_id(1, 6, 2, 7, 2'b11, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (ex_valid !== 1'b0) begin
            failed++;
            $display("FAIL reset ex_valid: got %b want 0", ex_valid);
        end
        tests++;
        if (ex_fwd_sel !== '0) begin
            failed++;
            $display("FAIL reset ex_fwd_sel: got %h want 0", ex_fwd_sel);
        end
        tests++;
        if (stall_count !== '0) begin
            failed++;
            $display("FAIL reset stall_count: got %0d want 0", stall_count);
        end
        tests++;
        if (hazard_stall !== 1'b0) begin
            failed++;
            $display("FAIL reset hazard: got %b want 0", hazard_stall);
        end
        reset = 1'b0;
        idle3();
    endtask

    task automatic test_alu_chain();
        stim_t seq[$];
        repeat (3) seq.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 5'b0_00_00));
        seq.push_back(mk(1, 3, 1, 2, 2'b11, 1, 0, 0, 5'b1_00_00));
        seq.push_back(mk(1, 4, 3, 3, 2'b11, 1, 0, 0, 5'b1_10_10));
        foreach (seq[i]) begin
            set_id(seq[i].v, seq[i].rd, seq[i].s0, seq[i].s1,
                   seq[i].used, seq[i].rw, seq[i].ld);
            #1;
            tests++;
            if (hazard_stall !== seq[i].hz) begin
                failed++;
                $display("FAIL alu_chain hz[%0d]: got %b want %b",
                         i, hazard_stall, seq[i].hz);
            end
            exp_q.push_back(seq[i].exp);
            tick();
            want = exp_q.pop_front();
            got  = {ex_valid, ex_fwd_sel};
            tests++;
            if (got !== want) begin
                failed++;
                $display("FAIL alu_chain ex[%0d]: got %b want %b",
                         i, got, want);
            end
        end
    endtask

    task automatic test_gap();
        stim_t seq[$];
        repeat (3) seq.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 5'b0_00_00));
        seq.push_back(mk(1, 3, 1, 2, 2'b11, 1, 0, 0, 5'b1_00_00));
        seq.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 5'b0_00_00));
        seq.push_back(mk(1, 5, 3, 1, 2'b11, 1, 0, 0, 5'b1_00_11));
        foreach (seq[i]) begin
            set_id(seq[i].v, seq[i].rd, seq[i].s0, seq[i].s1,
                   seq[i].used, seq[i].rw, seq[i].ld);
            #1;
            tests++;
            if (hazard_stall !== seq[i].hz) begin
                failed++;
                $display("FAIL gap hz[%0d]: got %b want %b",
                         i, hazard_stall, seq[i].hz);
            end
            exp_q.push_back(seq[i].exp);
            tick();
            want = exp_q.pop_front();
            got  = {ex_valid, ex_fwd_sel};
            tests++;
            if (got !== want) begin
                failed++;
                $display("FAIL gap ex[%0d]: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t seq[$];
        repeat (3) seq.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 5'b0_00_00));
        seq.push_back(mk(1, 2, 1, 0, 2'b01, 1, 1, 0, 5'b1_00_00));
        seq.push_back(mk(1, 6, 2, 7, 2'b11, 1, 0, 1, 5'b0_00_00));
        seq.push_back(mk(1, 6, 2, 7, 2'b11, 1, 0, 0, 5'b1_00_11));
        foreach (seq[i]) begin
            set_id(seq[i].v, seq[i].rd, seq[i].s0, seq[i].s1,
                   seq[i].used, seq[i].rw, seq[i].ld);
            #1;
            tests++;
            if (hazard_stall !== seq[i].hz) begin
                failed++;
                $display("FAIL load_use hz[%0d]: got %b want %b",
                         i, hazard_stall, seq[i].hz);
            end
            exp_q.push_back(seq[i].exp);
            tick();
            want = exp_q.pop_front();
            got  = {ex_valid, ex_fwd_sel};
            tests++;
            if (got !== want) begin
                failed++;
                $display("FAIL load_use ex[%0d]: got %b want %b",
                         i, got, want);
            end
        end
        tests++;
        if (stall_count !== 4'd1) begin
            failed++;
            $display("FAIL load_use count: got %0d want 1", stall_count);
        end
    endtask

    task automatic test_youngest();
        stim_t seq[$];
        repeat (3) seq.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 5'b0_00_00));
        seq.push_back(mk(1, 8, 1, 2, 2'b11, 1, 0, 0, 5'b1_00_00));
        seq.push_back(mk(1, 8, 1, 2, 2'b11, 1, 0, 0, 5'b1_00_00));
        seq.push_back(mk(1, 9, 8, 0, 2'b11, 1, 0, 0, 5'b1_00_10));
        foreach (seq[i]) begin
            set_id(seq[i].v, seq[i].rd, seq[i].s0, seq[i].s1,
                   seq[i].used, seq[i].rw, seq[i].ld);
            #1;
            tests++;
            if (hazard_stall !== seq[i].hz) begin
                failed++;
                $display("FAIL youngest hz[%0d]: got %b want %b",
                         i, hazard_stall, seq[i].hz);
            end
            exp_q.push_back(seq[i].exp);
            tick();
            want = exp_q.pop_front();
            got  = {ex_valid, ex_fwd_sel};
            tests++;
            if (got !== want) begin
                failed++;
                $display("FAIL youngest ex[%0d]: got %b want %b",
                         i, got, want);
            end
        end
    endtask

    task automatic test_freeze_flush();
        idle3();
        set_id(1, 3, 1, 2, 2'b11, 1, 0);
        exp_q.push_back(5'b1_00_00);
        tick();
        want = exp_q.pop_front();
        tests++;
        if ({ex_valid, ex_fwd_sel} !== want) begin
            failed++;
            $display("FAIL freeze pre0: got %b want %b",
                     {ex_valid, ex_fwd_sel}, want);
        end
        set_id(1, 4, 3, 3, 2'b11, 1, 0);
        exp_q.push_back(5'b1_10_10);
        tick();
        want = exp_q.pop_front();
        tests++;
        if ({ex_valid, ex_fwd_sel} !== want) begin
            failed++;
            $display("FAIL freeze pre1: got %b want %b",
                     {ex_valid, ex_fwd_sel}, want);
        end
        cnt0 = stall_count;
        set_id(1, 5, 4, 3, 2'b11, 1, 0);
        pipe_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(5'b1_10_10);
            #1;
            tests++;
            if (hazard_stall !== 1'b0) begin
                failed++;
                $display("FAIL freeze hz[%0d]: got %b want 0",
                         i, hazard_stall);
            end
            tick();
            want = exp_q.pop_front();
            tests++;
            if ({ex_valid, ex_fwd_sel} !== want) begin
                failed++;
                $display("FAIL freeze hold[%0d]: got %b want %b",
                         i, {ex_valid, ex_fwd_sel}, want);
            end
        end
        pipe_stall = 1'b0;
        exp_q.push_back(5'b1_11_10);
        tick();
        want = exp_q.pop_front();
        tests++;
        if ({ex_valid, ex_fwd_sel} !== want) begin
            failed++;
            $display("FAIL freeze release: got %b want %b",
                     {ex_valid, ex_fwd_sel}, want);
        end
        tests++;
        if (stall_count !== cnt0) begin
            failed++;
            $display("FAIL freeze count: got %0d want %0d",
                     stall_count, cnt0);
        end
        idle3();
        set_id(1, 2, 1, 0, 2'b01, 1, 1);
        exp_q.push_back(5'b1_00_00);
        tick();
        want = exp_q.pop_front();
        tests++;
        if ({ex_valid, ex_fwd_sel} !== want) begin
            failed++;
            $display("FAIL flush lw: got %b want %b",
                     {ex_valid, ex_fwd_sel}, want);
        end
        cnt0 = stall_count;
        set_id(1, 6, 2, 7, 2'b11, 1, 0);
        pipe_stall = 1'b1;
        #1;
        tests++;
        if (hazard_stall !== 1'b1) begin
            failed++;
            $display("FAIL frozen hz: got %b want 1", hazard_stall);
        end
        exp_q.push_back(5'b1_00_00);
        tick();
        want = exp_q.pop_front();
        tests++;
        if ({ex_valid, ex_fwd_sel} !== want) begin
            failed++;
            $display("FAIL frozen ex: got %b want %b",
                     {ex_valid, ex_fwd_sel}, want);
        end
        tests++;
        if (stall_count !== cnt0) begin
            failed++;
            $display("FAIL frozen count: got %0d want %0d",
                     stall_count, cnt0);
        end
        pipe_stall = 1'b0;
        flush = 1'b1;
        #1;
        tests++;
        if (hazard_stall !== 1'b0) begin
            failed++;
            $display("FAIL flush hz: got %b want 0", hazard_stall);
        end
        exp_q.push_back(5'b0_00_00);
        tick();
        want = exp_q.pop_front();
        tests++;
        if ({ex_valid, ex_fwd_sel} !== want) begin
            failed++;
            $display("FAIL flush ex: got %b want %b",
                     {ex_valid, ex_fwd_sel}, want);
        end
        tests++;
        if (stall_count !== cnt0) begin
            failed++;
            $display("FAIL flush count: got %0d want %0d",
                     stall_count, cnt0);
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_midstream();
        idle3();
        set_id(1, 2, 1, 0, 2'b01, 1, 1);
        tick();
        set_id(1, 6, 2, 7, 2'b11, 1, 0);
        #1;
        tests++;
        if (hazard_stall !== 1'b1) begin
            failed++;
            $display("FAIL midreset pre hz: got %b want 1", hazard_stall);
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({hazard_stall, ex_valid, ex_fwd_sel} !== 6'b0) begin
            failed++;
            $display("FAIL midreset clear: got %b want 000000",
                     {hazard_stall, ex_valid, ex_fwd_sel});
        end
        tests++;
        if (stall_count !== '0) begin
            failed++;
            $display("FAIL midreset count: got %0d want 0", stall_count);
        end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (hazard_stall !== 1'b0) begin
            failed++;
            $display("FAIL midreset forgot hz: got %b want 0",
                     hazard_stall);
        end
        exp_q.push_back(5'b1_00_00);
        tick();
        want = exp_q.pop_front();
        tests++;
        if ({ex_valid, ex_fwd_sel} !== want) begin
            failed++;
            $display("FAIL midreset ex: got %b want %b",
                     {ex_valid, ex_fwd_sel}, want);
        end
    endtask

    task automatic test_saturate_r0();
        for (int i = 0; i < 20; i++) begin
            set_id(1, 2, 1, 0, 2'b01, 1, 1);
            tick();
            set_id(1, 6, 2, 7, 2'b11, 1, 0);
            tick();
            tick();
            if (i == 13) begin
                tests++;
                if (stall_count !== 4'd14) begin
                    failed++;
                    $display("FAIL sat pre: got %0d want 14", stall_count);
                end
            end
            if (i == 14) begin
                tests++;
                if (stall_count !== 4'd15) begin
                    failed++;
                    $display("FAIL sat hit: got %0d want 15", stall_count);
                end
            end
        end
        tests++;
        if (stall_count !== 4'd15) begin
            failed++;
            $display("FAIL sat hold: got %0d want 15", stall_count);
        end
        idle3();
        set_id(1, 0, 1, 2, 2'b11, 1, 0);
        exp_q.push_back(5'b1_00_00);
        tick();
        want = exp_q.pop_front();
        tests++;
        if ({ex_valid, ex_fwd_sel} !== want) begin
            failed++;
            $display("FAIL r0 wr: got %b want %b",
                     {ex_valid, ex_fwd_sel}, want);
        end
        set_id(1, 5, 0, 0, 2'b11, 1, 0);
        exp_q.push_back(5'b1_00_00);
        tick();
        want = exp_q.pop_front();
        tests++;
        if ({ex_valid, ex_fwd_sel} !== want) begin
            failed++;
            $display("FAIL r0 fwd: got %b want %b",
                     {ex_valid, ex_fwd_sel}, want);
        end
        set_id(1, 0, 1, 0, 2'b01, 1, 1);
        tick();
        set_id(1, 6, 0, 0, 2'b11, 1, 0);
        #1;
        tests++;
        if (hazard_stall !== 1'b0) begin
            failed++;
            $display("FAIL r0 load hz: got %b want 0", hazard_stall);
        end
        exp_q.push_back(5'b1_00_00);
        tick();
        want = exp_q.pop_front();
        tests++;
        if ({ex_valid, ex_fwd_sel} !== want) begin
            failed++;
            $display("FAIL r0 load ex: got %b want %b",
                     {ex_valid, ex_fwd_sel}, want);
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        clk    = 1'b0;
        reset  = 1'b1;
        set_id(0, 0, 0, 0, 2'b00, 0, 0);
        test_reset();
        test_alu_chain();
        test_gap();
        test_load_use();
        test_youngest();
        test_freeze_flush();
        test_reset_midstream();
        test_saturate_r0();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
